// File: rtl/vreg_sequencer.sv
// vreg_sequencer
//   Steps one vector arithmetic instruction through VL in chunks of four
//   elements, one chunk per non-stalled cycle. For each chunk it drives the
//   vs1/vs2/vd register-file addresses. It also produces a write strobe and
//   an elements_to_write code, delayed by WB_LATENCY cycles to line up with
//   the PE pipeline. Only one instruction is in flight at a time.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o dispatch handshake (ready only in IDLE)
//   cmd_vs1_i/vs2_i/vd_i    base registers
//   cmd_vsew_i, cmd_vlmul_i element width code, LMUL code
//   cmd_vl_i                element count 0..32
//   cmd_widening_i          widening op (destination is 2*SEW)
//   cmd_wide_vs1_i          vs1 operand is 2*SEW
//   stall_i                 freezes issue, FSM and write pipeline
//   vs1/vs2/vd_addr_o       register file addresses
//   vsew_o, vlmul_o, widening_op_o, wide_vs1_o  latched instruction fields
//   elements_to_write_o     0 = all four, else 1..3
//   write_o                 register write strobe
//   busy_o, done_o, illegal_o  status (done/illegal are one-cycle pulses)
module vreg_sequencer #(
  parameter int WB_LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [4:0] cmd_vs1_i,
  input  logic [4:0] cmd_vs2_i,
  input  logic [4:0] cmd_vd_i,
  input  logic [1:0] cmd_vsew_i,
  input  logic [1:0] cmd_vlmul_i,
  input  logic [5:0] cmd_vl_i,
  input  logic       cmd_widening_i,
  input  logic       cmd_wide_vs1_i,
  input  logic       stall_i,
  output logic [4:0] vs1_addr_o,
  output logic [4:0] vs2_addr_o,
  output logic [4:0] vd_addr_o,
  output logic [1:0] vsew_o,
  output logic [1:0] vlmul_o,
  output logic       widening_op_o,
  output logic       wide_vs1_o,
  output logic [1:0] elements_to_write_o,
  output logic       write_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       illegal_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t     state_q;
  logic [4:0] vs1_q, vs2_q, vd_q;
  logic [1:0] vsew_q, vlmul_q;
  logic       widening_q, wide_vs1_q;
  logic [2:0] chunk_q;
  logic [5:0] remaining_q;
  logic       illegal_q;

  // Write-back pipeline: stage WB_LATENCY-1 is the one presented as write_o.
  logic       pipe_valid_q [WB_LATENCY];
  logic [4:0] pipe_vd_q    [WB_LATENCY];
  logic [1:0] pipe_etw_q   [WB_LATENCY];
  logic       pipe_busy;

  logic       cmd_illegal;
  logic [5:0] vlmax_base, vlmax, vl_eff;
  logic       issue, last_chunk;
  logic [1:0] eff_vsew;
  logic [4:0] chunk5, src_off, dst_off, issue_vd;
  logic [1:0] issue_etw;

  assign cmd_ready_o = (state_q == IDLE) && !stall_i && !reset_i;
  assign cmd_illegal = (cmd_vsew_i == 2'd3) || (cmd_widening_i && cmd_vsew_i == 2'd2);

  // vlmax = (4 >> vsew) << vlmul; widening ops use the source LMUL as given.
  assign vlmax_base = 6'd4 >> cmd_vsew_i;
  assign vlmax      = vlmax_base << cmd_vlmul_i;
  assign vl_eff     = (cmd_vl_i > vlmax) ? vlmax : cmd_vl_i;

  assign issue      = (state_q == ISSUE) && !stall_i;
  assign last_chunk = (remaining_q <= 6'd4);
  // Legal commands never combine widening with vsew=2, so this cannot overflow.
  assign eff_vsew   = vsew_q + {1'b0, widening_q};

  // Register offsets: chunk index times 1/2/4 registers, wrapping mod 32.
  assign chunk5    = {2'b00, chunk_q};
  assign src_off   = chunk5 << vsew_q;
  assign dst_off   = chunk5 << eff_vsew;
  assign issue_vd  = vd_q + dst_off;
  assign issue_etw = (remaining_q >= 6'd4) ? 2'd0 : remaining_q[1:0];

  assign vs1_addr_o = vs1_q + (wide_vs1_q ? dst_off : src_off);
  assign vs2_addr_o = vs2_q + src_off;

  // The retiring write owns vd_addr; the vs3 read in that cycle uses it too.
  assign write_o             = pipe_valid_q[WB_LATENCY-1] && !stall_i;
  assign vd_addr_o           = write_o ? pipe_vd_q[WB_LATENCY-1] : issue_vd;
  assign elements_to_write_o = write_o ? pipe_etw_q[WB_LATENCY-1] : 2'd0;

  assign done_o        = (state_q == DRAIN) && !pipe_busy && !stall_i;
  assign busy_o        = (state_q != IDLE);
  assign illegal_o     = illegal_q;
  assign vsew_o        = vsew_q;
  assign vlmul_o       = vlmul_q;
  assign widening_op_o = widening_q;
  assign wide_vs1_o    = wide_vs1_q;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < WB_LATENCY; i++) begin
      pipe_busy = pipe_busy | pipe_valid_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      vs1_q       <= 5'd0;
      vs2_q       <= 5'd0;
      vd_q        <= 5'd0;
      vsew_q      <= 2'd0;
      vlmul_q     <= 2'd0;
      widening_q  <= 1'b0;
      wide_vs1_q  <= 1'b0;
      chunk_q     <= 3'd0;
      remaining_q <= 6'd0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (!stall_i) begin
        case (state_q)
          IDLE: begin
            if (cmd_valid_i) begin
              if (cmd_illegal) begin
                illegal_q <= 1'b1;
              end else begin
                vs1_q       <= cmd_vs1_i;
                vs2_q       <= cmd_vs2_i;
                vd_q        <= cmd_vd_i;
                vsew_q      <= cmd_vsew_i;
                vlmul_q     <= cmd_vlmul_i;
                widening_q  <= cmd_widening_i;
                wide_vs1_q  <= cmd_wide_vs1_i;
                chunk_q     <= 3'd0;
                remaining_q <= vl_eff;
                // Zero-length instructions skip ISSUE; DRAIN sees an empty pipe.
                state_q     <= (vl_eff == 6'd0) ? DRAIN : ISSUE;
              end
            end
          end
          ISSUE: begin
            chunk_q     <= chunk_q + 3'd1;
            remaining_q <= last_chunk ? 6'd0 : remaining_q - 6'd4;
            if (last_chunk) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (!pipe_busy) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_valid_q[0] <= 1'b0;
      pipe_vd_q[0]    <= 5'd0;
      pipe_etw_q[0]   <= 2'd0;
    end else if (!stall_i) begin
      pipe_valid_q[0] <= issue;
      pipe_vd_q[0]    <= issue_vd;
      pipe_etw_q[0]   <= issue_etw;
    end
  end

  for (genvar gi = 1; gi < WB_LATENCY; gi++) begin : g_wb_stage
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        pipe_valid_q[gi] <= 1'b0;
        pipe_vd_q[gi]    <= 5'd0;
        pipe_etw_q[gi]   <= 2'd0;
      end else if (!stall_i) begin
        pipe_valid_q[gi] <= pipe_valid_q[gi-1];
        pipe_vd_q[gi]    <= pipe_vd_q[gi-1];
        pipe_etw_q[gi]   <= pipe_etw_q[gi-1];
      end
    end
  end

endmodule

// File: doc/vreg_sequencer.md
Name: vreg_sequencer

Overview:
- Issues one vector arithmetic instruction at a time to the vector register file and PE array, stepping through VL in chunks of 4 elements (one chunk per cycle).
- Per chunk, generates base register addresses for vs1/vs2/vd, the reg-file SEW/LMUL/widening controls, a write strobe and the elements_to_write code.
- The write-back for each chunk is delayed to match the PE pipeline latency.
- Sits between the decode/dispatch stage and vector_registers/PE array; one instruction in flight, no overlap.

Parameters:
- WB_LATENCY, 2, cycles from a chunk's read issue to its register write (legal range 1..8).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  instruction available.
- cmd_ready  output  1  sequencer can accept (high only in IDLE).
- cmd_vs1  input  5  vs1 base register.
- cmd_vs2  input  5  vs2 base register.
- cmd_vd  input  5  vd base register.
- cmd_vsew  input  2  0=8b, 1=16b, 2=32b (3 is illegal).
- cmd_vlmul  input  2  0..3 = LMUL 1,2,4,8.
- cmd_vl  input  6  element count, 0..32.
- cmd_widening  input  1  widening op.
- cmd_wide_vs1  input  1  vs1 is a 2*SEW operand.
- stall  input  1  freeze issue and write pipeline.
- vs1_addr, vs2_addr, vd_addr  output  5 each  register file addresses.
- vsew, vlmul  output  2 each  latched instruction fields.
- widening_op, wide_vs1  output  1 each  latched flags.
- elements_to_write  output  2  0=all 4, else 1..3.
- write  output  1  register write strobe.
- busy  output  1  instruction in flight.
- done  output  1  one-cycle pulse after the last write retires.
- illegal  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; chunk counter, latched fields and write pipeline cleared. Reset mid-instruction discards in-flight writes; no done pulse.
- FSM states: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: cmd_ready=1. Accept on cmd_valid & cmd_ready and latch all fields.
  - Illegal command (vsew=3, or widening with vsew=2): pulse illegal next cycle, stay IDLE, no writes, no done.
  - vl_eff = min(cmd_vl, vlmax), where vlmax = (4>>vsew)<<vlmul.
  - For wide_vs1 or widening, LMUL is the source LMUL.
  - nchunks = ceil(vl_eff/4). If vl_eff=0: go to DRAIN directly with zero writes; done pulses exactly 1 cycle after acceptance.
- ISSUE: one chunk per non-stalled cycle, c=0..nchunks-1.
  - Source step src_step = 1<<vsew (1, 2 or 4 registers per chunk).
  - Destination step dst_step = 1<<eff_vsew, where eff_vsew = vsew+widening.
  - vs1_addr = cmd_vs1 + c*(wide_vs1 ? dst_step : src_step).
  - vs2_addr = cmd_vs2 + c*src_step.
  - Issue-side vd_addr (vs3 read) = cmd_vd + c*dst_step. All address arithmetic is mod 32.
  - Addresses are valid in the cycle the chunk issues. After the last chunk, go to DRAIN.
- Write pipeline: WB_LATENCY-deep shift register of {valid, vd_addr, elements_to_write}.
  - Per chunk, etw = (remaining>=4) ? 0 : remaining, with remaining = vl_eff - 4c.
  - write asserts for exactly one cycle WB_LATENCY non-stalled cycles after the chunk issues.
  - While write is high, vd_addr and elements_to_write carry the pipelined values, which override the issue-side vd_addr.
  - With WB_LATENCY≥1 and no overlap, a write cycle and an issue cycle coincide: vd_addr shows the write address and the vs3 read uses the same register.
- stall=1 freezes the counter, FSM and pipeline; write is forced to 0 while stalled and the pending write is held.
- DRAIN: wait until the pipeline is empty, then pulse done and return to IDLE.
- busy = (state != IDLE).
- cmd_ready is 0 during the done cycle; a new command is accepted the cycle after done.
- Latched vsew/vlmul/widening_op/wide_vs1 hold until the next acceptance.
- No check on base alignment. Misaligned bases are a software error; behaviour is as defined by the address formula.

Test Plan:
1. WB_LATENCY=2, vsew=0, vlmul=0, vl=4, vs1=1, vs2=2, vd=3:
   - Chunk issued at cycle t+1 with vs1/vs2/vd addr 1/2/3.
   - write at t+3 with vd_addr=3, etw=0.
   - done at t+4.
2. vsew=0, vlmul=2, vl=10, vs2=4, vd=8:
   - vs2 addr 4, 5, 6; writes to vd 8, 9, 10 with etw 0, 0, 2.
   - Exactly 3 write pulses, then done.
3. Widening: vsew=0, vlmul=1, vl=6, vs2=4, vd=8:
   - vs2 addr 4, 5; vd writes 8, 10 with etw 0, 2.
   - widening_op=1 throughout.
4. Clamp and zero VL:
   - vsew=2, vlmul=0, vl=9 → one chunk with etw=1.
   - vl=0 → no write; done 1 cycle after acceptance.
   - vsew=3 → illegal pulse, cmd_ready stays 1.
5. Stall and reset:
   - Stall for 3 cycles mid-ISSUE of scenario 2: the address sequence is unchanged, with no duplicate or missing writes.
   - Assert reset between the 2nd and 3rd write: outputs go to 0 at once, no further writes, no done; the next command runs normally.
